lfsr_rand_arbiter: RTL and testbench
====================================

Name: lfsr_rand_arbiter

Overview:
- Shares one 8-bit Fibonacci-style LFSR random source among N_REQ requesters using round-robin arbitration.
- Each grant delivers one random byte, then steps the LFSR STEPS times before the next grant, so consecutive consumers never see the same byte.
- Provides a seed-load port for deterministic test runs.
- Sits between the random-number consumers (test/stimulus logic, games, address scramblers) and the pseudo-random datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- STEPS, 1, LFSR advance cycles after each grant (1..15).
- SEED, 8'h01, LFSR value after reset. A value of 8'h00 is replaced by 8'h01.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  level request per requester; held until its gnt bit pulses.
- seed_we  in  1  load seed_data into the LFSR this cycle.
- seed_data  in  8  seed value.
- gnt  out  N_REQ  one-hot grant, one-cycle pulse.
- rnd_valid  out  1  high for exactly the cycle gnt is nonzero.
- rnd_data  out  8  random byte for the granted requester; valid with rnd_valid.
- rnd_id  out  $clog2(N_REQ)  index of the granted requester.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Clock, reset, sampling: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - lfsr = SEED (8'h01 if SEED == 0).
  - State IDLE; round-robin pointer ptr = 0.
  - gnt = 0, rnd_valid = 0, rnd_data = 8'h00, rnd_id = 0, busy = 0.
  - Reset overrides all other inputs, including mid-advance.
- LFSR step: next = {l[4]^l[3]^l[2]^l[0], l[7:1]}. If lfsr is ever 8'h00, the next edge forces 8'h01 (lock-up recovery).
  - From 8'h01 the sequence is 01, 80, 40, 20, 10, 88, C4, ...
- FSM states: IDLE, ADV.
- IDLE:
  - If seed_we: lfsr <= seed_data (8'h00 maps to 8'h01); no grant; stay in IDLE.
  - Else if req != 0: the winner is the first set bit searching from index ptr upward, wrapping mod N_REQ. On the next edge:
    - gnt[w] = 1, rnd_valid = 1, rnd_id = w.
    - rnd_data = lfsr value as sampled in the arbitration cycle (pre-advance).
    - ptr = (w+1) mod N_REQ; step counter = STEPS; state -> ADV.
  - Else: hold; the LFSR does not advance.
- ADV:
  - gnt and rnd_valid are high only in the first ADV cycle, then 0. rnd_data and rnd_id hold their last values.
  - Each cycle the LFSR steps once and the counter decrements. When the counter reaches 0, state -> IDLE.
  - req is ignored in ADV.
- Timing:
  - Latency from req sampled in IDLE to gnt is 1 cycle.
  - Minimum spacing between grants is STEPS+1 cycles.
- seed_we in ADV: lfsr <= seed (zero maps to 01), remaining steps are aborted, state -> IDLE next edge. ptr is unchanged. A gnt pulse already registered this cycle still completes normally.
- Requesters must drop req the cycle after seeing their gnt bit; a still-high req is treated as a new request.
- Non-requesting indices are skipped with no idle cycle. A single requester may win back-to-back.

Test Plan:
- Single requester: reset, STEPS=1, req=4'b0001 held one cycle at T.
  - Expect at T+1: gnt=0001, rnd_valid=1, rnd_id=0, rnd_data=8'h01, busy=1.
  - A repeat request then yields rnd_data=8'h80.
- Full contention: req=4'b1111 held, STEPS=1.
  - Expect grants to ids 0,1,2,3,0 every 2 cycles with rnd_data 01,80,40,20,10.
  - Expect rnd_valid never high on two consecutive cycles.
- Zero seed: seed_we=1, seed_data=8'h00 in IDLE, then req[2].
  - Expect rnd_id=2 and rnd_data=8'h01.
- Seed abort in ADV: STEPS=4; req[1] grant; assert seed_we with 8'hA5 during the 2nd ADV cycle.
  - Expect busy=0 on the next cycle.
  - A following req[3] returns rnd_data=8'hA5, rnd_id=3.
- Seed vs request collision: seed_we=1 with seed 8'h3C and req=4'b0100 in the same IDLE cycle.
  - Expect no gnt on the next cycle.
  - The grant one cycle later carries rnd_data=8'h3C, rnd_id=2.
- Reset mid-advance: rst=1 during ADV with STEPS=8.
  - Expect all outputs at reset values, lfsr=SEED, ptr=0.
  - The next req=4'b1010 grants id 1 with rnd_data=8'h01.

Source files
------------

// File: rtl/lfsr_rand_arbiter.sv
// lfsr_rand_arbiter: round-robin arbiter sharing one 8-bit Fibonacci LFSR.
// Each grant hands out one byte, then the LFSR advances STEPS times.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req[N_REQ]            level requests, dropped after the matching gnt bit
//   seed_we, seed_data    load a new LFSR seed (zero maps to 8'h01)
//   gnt[N_REQ]            one-hot one-cycle grant pulse
//   rnd_valid, rnd_data   byte for the granted requester, valid with gnt
//   rnd_id                index of the granted requester
//   busy                  high while the LFSR is advancing after a grant
module lfsr_rand_arbiter #(
    parameter int          N_REQ = 4,
    parameter int          STEPS = 1,
    parameter logic [7:0]  SEED  = 8'h01,
    localparam int         IDW   = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             seed_we,
    input  logic [7:0]       seed_data,
    output logic [N_REQ-1:0] gnt,
    output logic             rnd_valid,
    output logic [7:0]       rnd_data,
    output logic [IDW-1:0]   rnd_id,
    output logic             busy
);

    localparam logic [7:0]   SEED_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [IDW:0] NREQ_W    = (IDW+1)'(N_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    typedef enum logic {IDLE, ADV} state_t;

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             rnd_valid_q, rnd_valid_d;
    logic [7:0]       rnd_data_q, rnd_data_d;
    logic [IDW-1:0]   rnd_id_q, rnd_id_d;
    logic             busy_q, busy_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW:0]     sum;

    // Zero is the LFSR lock-up state; it is never allowed to persist.
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        if (l == 8'h00) return 8'h01;
        return {l[4] ^ l[3] ^ l[2] ^ l[0], l[7:1]};
    endfunction

    function automatic logic [7:0] seed_fix(input logic [7:0] s);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    // Round-robin search: first set request at or above ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum >= NREQ_W) sum = sum - NREQ_W;
            if (!win_found && req[sum[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lfsr_d      = (lfsr_q == 8'h00) ? 8'h01 : lfsr_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_data_d  = rnd_data_q;
        rnd_id_d    = rnd_id_q;
        unique case (state_q)
            IDLE: begin
                if (seed_we) begin
                    lfsr_d = seed_fix(seed_data);
                end else if (win_found) begin
                    gnt_d[win_idx] = 1'b1;
                    rnd_valid_d    = 1'b1;
                    rnd_data_d     = lfsr_q;
                    rnd_id_d       = win_idx;
                    ptr_d          = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
                    cnt_d          = 4'(STEPS);
                    state_d        = ADV;
                end
            end
            ADV: begin
                if (seed_we) begin
                    // A reseed abandons the remaining advance steps.
                    lfsr_d  = seed_fix(seed_data);
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    lfsr_d = lfsr_next(lfsr_q);
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ADV);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED_INIT;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_data_q  <= 8'h00;
            rnd_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_data_q  <= rnd_data_d;
            rnd_id_q    <= rnd_id_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_id    = rnd_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// tb_lfsr_rand_arbiter: three arbiters (STEPS 1, 4, 8) on shared inputs,
// directed scenarios plus a randomized run against a behavioural model.
module tb_lfsr_rand_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = '0;
    logic       seed_we = 1'b0;
    logic [7:0] seed_data = '0;

    logic [3:0] gnt_o  [3];
    logic       rv_o   [3];
    logic [7:0] rd_o   [3];
    logic [1:0] rid_o  [3];
    logic       busy_o [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        lfsr_rand_arbiter #(
            .N_REQ(4),
            .STEPS((k == 0) ? 1 : (k == 1) ? 4 : 8),
            .SEED(8'h01)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .req      (req),
            .seed_we  (seed_we),
            .seed_data(seed_data),
            .gnt      (gnt_o[k]),
            .rnd_valid(rv_o[k]),
            .rnd_data (rd_o[k]),
            .rnd_id   (rid_o[k]),
            .busy     (busy_o[k])
        );
    end

    // Observation bundle: {gnt, rnd_valid, rnd_id, rnd_data, busy}
    function automatic logic [15:0] obs(input int k);
        return {gnt_o[k], rv_o[k], rid_o[k], rd_o[k], busy_o[k]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; seed_we = 1'b0; seed_data = '0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs(k) !== 16'h0000) begin
                n_errors++;
                $display("FAIL reset k=%0d got %h exp %h", k, obs(k), 16'h0000);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [15:0] e;
        test_reset();
        req = 4'b0001; cyc();
        e = {4'b0001, 1'b1, 2'd0, 8'h01, 1'b1};
        n_checks++;
        if (obs(0) !== e) begin
            n_errors++; $display("FAIL single1 got %h exp %h", obs(0), e);
        end
        req = 4'b0000; cyc();
        e = {4'b0000, 1'b0, 2'd0, 8'h01, 1'b0};
        n_checks++;
        if (obs(0) !== e) begin
            n_errors++; $display("FAIL single_gap got %h exp %h", obs(0), e);
        end
        req = 4'b0001; cyc();
        e = {4'b0001, 1'b1, 2'd0, 8'h80, 1'b1};
        n_checks++;
        if (obs(0) !== e) begin
            n_errors++; $display("FAIL single2 got %h exp %h", obs(0), e);
        end
        req = '0;
    endtask

    task automatic test_contention();
        logic [7:0]  d [5];
        logic [15:0] e;
        int          n;
        d[0] = 8'h01; d[1] = 8'h80; d[2] = 8'h40; d[3] = 8'h20; d[4] = 8'h10;
        test_reset();
        req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            cyc();
            n = c / 2;
            if (c % 2 == 0)
                e = {4'b0001 << (n % 4), 1'b1, 2'(n % 4), d[n], 1'b1};
            else
                e = {4'b0000, 1'b0, 2'(n % 4), d[n], 1'b0};
            n_checks++;
            if (obs(0) !== e) begin
                n_errors++;
                $display("FAIL contention c=%0d got %h exp %h", c, obs(0), e);
            end
        end
        req = '0;
    endtask

    task automatic test_zero_seed();
        logic [15:0] e;
        test_reset();
        req = 4'b0001; cyc();
        req = 4'b0000; cyc();
        seed_we = 1'b1; seed_data = 8'h00; cyc();
        e = {4'b0000, 1'b0, 2'd0, 8'h01, 1'b0};
        n_checks++;
        if (obs(0) !== e) begin
            n_errors++; $display("FAIL zero_seed_load got %h exp %h", obs(0), e);
        end
        seed_we = 1'b0; req = 4'b0100; cyc();
        e = {4'b0100, 1'b1, 2'd2, 8'h01, 1'b1};
        n_checks++;
        if (obs(0) !== e) begin
            n_errors++; $display("FAIL zero_seed_gnt got %h exp %h", obs(0), e);
        end
        req = '0;
    endtask

    task automatic test_seed_abort();
        logic [15:0] e;
        test_reset();
        req = 4'b0010; cyc();
        e = {4'b0010, 1'b1, 2'd1, 8'h01, 1'b1};
        n_checks++;
        if (obs(1) !== e) begin
            n_errors++; $display("FAIL abort_gnt got %h exp %h", obs(1), e);
        end
        req = 4'b0000; cyc();
        e = {4'b0000, 1'b0, 2'd1, 8'h01, 1'b1};
        n_checks++;
        if (obs(1) !== e) begin
            n_errors++; $display("FAIL abort_adv got %h exp %h", obs(1), e);
        end
        seed_we = 1'b1; seed_data = 8'hA5; cyc();
        e = {4'b0000, 1'b0, 2'd1, 8'h01, 1'b0};
        n_checks++;
        if (obs(1) !== e) begin
            n_errors++; $display("FAIL abort_idle got %h exp %h", obs(1), e);
        end
        seed_we = 1'b0; req = 4'b1000; cyc();
        e = {4'b1000, 1'b1, 2'd3, 8'hA5, 1'b1};
        n_checks++;
        if (obs(1) !== e) begin
            n_errors++; $display("FAIL abort_next got %h exp %h", obs(1), e);
        end
        req = '0;
    endtask

    task automatic test_collision();
        logic [15:0] e;
        test_reset();
        seed_we = 1'b1; seed_data = 8'h3C; req = 4'b0100; cyc();
        e = 16'h0000;
        n_checks++;
        if (obs(0) !== e) begin
            n_errors++; $display("FAIL collide_nognt got %h exp %h", obs(0), e);
        end
        seed_we = 1'b0; cyc();
        e = {4'b0100, 1'b1, 2'd2, 8'h3C, 1'b1};
        n_checks++;
        if (obs(0) !== e) begin
            n_errors++; $display("FAIL collide_gnt got %h exp %h", obs(0), e);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] e;
        test_reset();
        req = 4'b0100; cyc();
        req = 4'b0000; cyc(); cyc();
        e = {4'b0000, 1'b0, 2'd2, 8'h01, 1'b1};
        n_checks++;
        if (obs(2) !== e) begin
            n_errors++; $display("FAIL midrst_busy got %h exp %h", obs(2), e);
        end
        rst = 1'b1; cyc();
        e = 16'h0000;
        n_checks++;
        if (obs(2) !== e) begin
            n_errors++; $display("FAIL midrst_vals got %h exp %h", obs(2), e);
        end
        rst = 1'b0; req = 4'b1010; cyc();
        e = {4'b0010, 1'b1, 2'd1, 8'h01, 1'b1};
        n_checks++;
        if (obs(2) !== e) begin
            n_errors++; $display("FAIL midrst_next got %h exp %h", obs(2), e);
        end
        req = '0;
    endtask

    task automatic test_random();
        logic [7:0]  m_lfsr [3];
        int          m_ptr  [3];
        int          m_wait [3];
        logic [7:0]  m_rd   [3];
        int          m_rid  [3];
        int          steps  [3];
        logic [3:0]  e_gnt;
        logic        e_rv;
        logic [15:0] e;
        int          w;
        steps[0] = 1; steps[1] = 4; steps[2] = 8;
        for (int c = 0; c < 600; c++) begin
            rst       = (c == 0) || ($urandom_range(0, 79) == 0);
            req       = 4'($urandom);
            seed_we   = ($urandom_range(0, 7) == 0);
            seed_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cyc();
            for (int k = 0; k < 3; k++) begin
                e_gnt = '0;
                e_rv  = 1'b0;
                if (rst) begin
                    m_lfsr[k] = 8'h01; m_ptr[k] = 0; m_wait[k] = 0;
                    m_rd[k] = 8'h00; m_rid[k] = 0;
                end else if (m_wait[k] == 0) begin
                    if (seed_we) begin
                        m_lfsr[k] = (seed_data == 0) ? 8'h01 : seed_data;
                    end else if (req != 0) begin
                        w = -1;
                        for (int i = 0; i < 4; i++)
                            if (w < 0 && req[(m_ptr[k] + i) % 4])
                                w = (m_ptr[k] + i) % 4;
                        e_gnt     = 4'b0001 << w;
                        e_rv      = 1'b1;
                        m_rd[k]   = m_lfsr[k];
                        m_rid[k]  = w;
                        m_ptr[k]  = (w + 1) % 4;
                        m_wait[k] = steps[k];
                    end
                end else if (seed_we) begin
                    m_lfsr[k] = (seed_data == 0) ? 8'h01 : seed_data;
                    m_wait[k] = 0;
                end else begin
                    m_lfsr[k] = {m_lfsr[k][4] ^ m_lfsr[k][3] ^ m_lfsr[k][2]
                                 ^ m_lfsr[k][0], m_lfsr[k][7:1]};
                    m_wait[k] = m_wait[k] - 1;
                end
                e = {e_gnt, e_rv, 2'(m_rid[k]), m_rd[k], m_wait[k] != 0};
                n_checks++;
                if (obs(k) !== e) begin
                    n_errors++;
                    $display("FAIL random k=%0d c=%0d got %h exp %h",
                             k, c, obs(k), e);
                end
            end
        end
        rst = 1'b0; req = '0; seed_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_zero_seed();
        test_seed_abort();
        test_collision();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
